// File: rtl/kwta_pkg.sv
// Shared types and constants for the k-winner-take-all inhibit controller.
// The optional winner_mask output is enabled by defining KWTA_MASK_OUT_EN.
package kwta_pkg;
   localparam int N_DEF         = 16;
   localparam int K_DEF         = 1;
   localparam int GAMMA_LEN_DEF = 64;

   typedef enum logic [1:0] {IDLE, ARMED, INHIBIT} kwta_state_e;

   // Bit width needed to hold values 0..v-1, never less than one bit.
   function automatic int cw(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction
endpackage

// File: rtl/spike_edge_encoder.sv
// Combinational summary of a spike-edge vector: popcount, lowest set index, any.
module spike_edge_encoder import kwta_pkg::*; #(
   parameter int N = N_DEF
) (
   input  logic [N-1:0]          i_edge,
   output logic [cw(N+1)-1:0]    o_pop,
   output logic [cw(N)-1:0]      o_idx,
   output logic                  o_any
);
   localparam int PW = cw(N+1);
   localparam int IW = cw(N);

   // Scan downward so the lowest set index is the last one written.
   always_comb begin
      o_pop = '0;
      o_idx = '0;
      for (int i = N-1; i >= 0; i--) begin
         o_pop = o_pop + PW'(i_edge[i]);
         if (i_edge[i]) o_idx = IW'(i);
      end
   end

   assign o_any = |i_edge;
endmodule

// File: rtl/kwta_inhibit_ctrl.sv
// k-WTA controller: counts 1->0 spike edges per gamma window and asserts inhibit after K.
// Define KWTA_MASK_OUT_EN to add the winner_mask output and its register.
module kwta_inhibit_ctrl import kwta_pkg::*; #(
   parameter int N         = N_DEF,
   parameter int K         = K_DEF,
   parameter int GAMMA_LEN = GAMMA_LEN_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  gamma_start,
   input  logic [N-1:0]          spikes_in,
   output logic                  inhibit,
   output logic [cw(N)-1:0]      winner_idx,
   output logic                  winner_valid,
   output logic [cw(N+1)-1:0]    spike_count,
   output logic                  done
`ifdef KWTA_MASK_OUT_EN
   ,output logic [N-1:0]         winner_mask
`endif
);
   localparam int IW = cw(N);
   localparam int CW = cw(N+1);
   localparam int TW = cw(GAMMA_LEN);
   localparam logic [CW:0]   NSAT  = (CW+1)'(N);
   localparam logic [CW-1:0] KV    = CW'(K);
   localparam logic [TW-1:0] T_END = TW'(GAMMA_LEN-1);

   kwta_state_e   r_state, w_state_nxt;
   logic [N-1:0]  r_prev_spk;
   logic [TW-1:0] r_cnt;
   logic [CW-1:0] r_count;
   logic [IW-1:0] r_idx;
   logic          r_valid;
   logic          r_inhibit;

   logic [N-1:0]  w_edge;
   logic [CW-1:0] w_pop;
   logic [IW-1:0] w_idx;
   logic          w_any;
   logic [CW:0]   w_sum;
   logic [CW-1:0] w_count_nxt;
   logic          w_active;
   logic          w_last;
   logic          w_done;

   assign w_edge = r_prev_spk & ~spikes_in;

   spike_edge_encoder #(.N(N)) u_enc (
      .i_edge (w_edge),
      .o_pop  (w_pop),
      .o_idx  (w_idx),
      .o_any  (w_any)
   );

   assign w_active    = (r_state != IDLE);
   assign w_last      = (r_cnt == T_END);
   assign w_sum       = {1'b0, r_count} + {1'b0, w_pop};
   assign w_count_nxt = (w_sum > NSAT) ? CW'(N) : w_sum[CW-1:0];

   // A new gamma_start always wins, including over the window's last cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      if (gamma_start) begin
         w_state_nxt = ARMED;
      end else begin
         case (r_state)
            IDLE: w_state_nxt = IDLE;
            ARMED: begin
               if (w_last) begin
                  w_state_nxt = IDLE;
                  w_done      = 1'b1;
               end else if (w_count_nxt >= KV) begin
                  w_state_nxt = INHIBIT;
               end
            end
            INHIBIT: begin
               if (w_last) begin
                  w_state_nxt = IDLE;
                  w_done      = 1'b1;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_prev_spk <= '1;
         r_cnt      <= '0;
         r_count    <= '0;
         r_idx      <= '0;
         r_valid    <= 1'b0;
         r_inhibit  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_prev_spk <= spikes_in;
         r_inhibit  <= (w_state_nxt == INHIBIT);
         if (gamma_start) begin
            r_cnt   <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
         end else if (w_active) begin
            r_count <= w_count_nxt;
            if (!r_valid && w_any) begin
               r_idx   <= w_idx;
               r_valid <= 1'b1;
            end
            // Counter parks on the last value; it is cleared by the next gamma_start.
            if (!w_last) r_cnt <= r_cnt + TW'(1);
         end
      end
   end

`ifdef KWTA_MASK_OUT_EN
   logic [N-1:0] r_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_mask <= '0;
      else if (gamma_start)       r_mask <= '0;
      else if (r_state == ARMED)  r_mask <= r_mask | w_edge;
   end

   assign winner_mask = r_mask;
`endif

   assign inhibit      = r_inhibit;
   assign winner_idx   = r_idx;
   assign winner_valid = r_valid;
   assign spike_count  = r_count;
   assign done         = w_done;
endmodule

// File: tb/tb_kwta_inhibit_ctrl.sv
// Randomized + directed bench: three controllers (K=1,2,3) share stimulus and are
// checked every cycle against a window-history reference model.
module tb_kwta_inhibit_ctrl;
   localparam int N  = 16;
   localparam int GL = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          gamma_start = 1'b0;
   logic [N-1:0]  spikes_in = '1;

   logic          inh [3];
   logic [3:0]    widx [3];
   logic          wval [3];
   logic [4:0]    cnt [3];
   logic          dn [3];
`ifdef KWTA_MASK_OUT_EN
   logic [N-1:0]  msk [3];
`endif

   int Ks [3] = '{1, 2, 3};

   always #5 clk = ~clk;

   kwta_inhibit_ctrl #(.N(N), .K(1), .GAMMA_LEN(GL)) u_k1 (
      .clk(clk), .rst_n(rst_n), .gamma_start(gamma_start), .spikes_in(spikes_in),
      .inhibit(inh[0]), .winner_idx(widx[0]), .winner_valid(wval[0]),
      .spike_count(cnt[0]), .done(dn[0])
`ifdef KWTA_MASK_OUT_EN
      , .winner_mask(msk[0])
`endif
   );
   kwta_inhibit_ctrl #(.N(N), .K(2), .GAMMA_LEN(GL)) u_k2 (
      .clk(clk), .rst_n(rst_n), .gamma_start(gamma_start), .spikes_in(spikes_in),
      .inhibit(inh[1]), .winner_idx(widx[1]), .winner_valid(wval[1]),
      .spike_count(cnt[1]), .done(dn[1])
`ifdef KWTA_MASK_OUT_EN
      , .winner_mask(msk[1])
`endif
   );
   kwta_inhibit_ctrl #(.N(N), .K(3), .GAMMA_LEN(GL)) u_k3 (
      .clk(clk), .rst_n(rst_n), .gamma_start(gamma_start), .spikes_in(spikes_in),
      .inhibit(inh[2]), .winner_idx(widx[2]), .winner_valid(wval[2]),
      .spike_count(cnt[2]), .done(dn[2])
`ifdef KWTA_MASK_OUT_EN
      , .winner_mask(msk[2])
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: the edge vector seen at every window position so far.
   logic [N-1:0] hist [GL];
   logic [N-1:0] mprev;
   bit           mact;
   int           mc;

   function automatic int cum(input int upto);
      int s = 0;
      for (int p = 0; p < upto; p++) s += $countones(hist[p]);
      return (s > N) ? N : s;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < GL; p++) hist[p] = '0;
      mprev = '1;
      mact  = 0;
      mc    = 0;
   endtask

   task automatic model_step(input logic gs, input logic [N-1:0] spk);
      logic [N-1:0] e;
      e = mprev & ~spk;
      if (gs) begin
         for (int p = 0; p < GL; p++) hist[p] = '0;
         mact = 1;
         mc   = 0;
      end else if (mact) begin
         hist[mc] = e;
         mc++;
         if (mc == GL) mact = 0;
      end
      mprev = spk;
   endtask

   task automatic check_all(input logic gs);
      bit e_val = 0;
      int e_idx = 0;
      int e_cnt;
      for (int p = 0; p < mc && !e_val; p++)
         if (hist[p] != '0) begin
            e_val = 1;
            for (int i = N-1; i >= 0; i--) if (hist[p][i]) e_idx = i;
         end
      e_cnt = cum(mc);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("k%0d.inhibit", Ks[d]), int'(inh[d]), int'(mact && e_cnt >= Ks[d]));
         chk($sformatf("k%0d.count", Ks[d]), int'(cnt[d]), e_cnt);
         chk($sformatf("k%0d.valid", Ks[d]), int'(wval[d]), int'(e_val));
         if (e_val) chk($sformatf("k%0d.idx", Ks[d]), int'(widx[d]), e_idx);
         chk($sformatf("k%0d.done", Ks[d]), int'(dn[d]), int'(mact && mc == GL-1 && !gs));
`ifdef KWTA_MASK_OUT_EN
         begin
            logic [N-1:0] em = '0;
            for (int p = 0; p < mc; p++) if (cum(p) < Ks[d]) em |= hist[p];
            chk($sformatf("k%0d.mask", Ks[d]), int'(msk[d]), int'(em));
         end
`endif
      end
   endtask

   task automatic cyc(input logic gs, input logic [N-1:0] spk);
      @(negedge clk);
      gamma_start = gs;
      spikes_in   = spk;
      #1;
      check_all(gs);
      model_step(gs, spk);
   endtask

   // Fall schedule for the current window, relative to its gamma_start cycle (-1 = never).
   int f [N];

   task automatic clr_f();
      for (int i = 0; i < N; i++) f[i] = -1;
   endtask

   task automatic run_win(input int ncyc, input int abort_at);
      logic [N-1:0] spk;
      for (int t = 0; t < ncyc; t++) begin
         for (int i = 0; i < N; i++) spk[i] = !(f[i] >= 0 && t >= f[i]);
         cyc(t == 0 || t == abort_at, spk);
      end
   endtask

   initial begin
      model_reset();
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("rst.inhibit", int'(inh[d]), 0);
         chk("rst.count", int'(cnt[d]), 0);
         chk("rst.idx", int'(widx[d]), 0);
         chk("rst.valid", int'(wval[d]), 0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc(0, '1);

      // Line 1 at 5, line 13 at 7; run past the window end.
      clr_f(); f[1] = 5; f[13] = 7;
      run_win(68, -1);
      chk("t2.idx", int'(widx[0]), 1);
      chk("t2.count", int'(cnt[0]), 2);

      // Lines 5, 12, 4 at 3, 4, 8.
      clr_f(); f[5] = 3; f[12] = 4; f[4] = 8;
      run_win(66, -1);
      chk("t3.idx", int'(widx[2]), 5);
      chk("t3.count", int'(cnt[2]), 3);

      // Simultaneous edges on lines 10, 3, 15.
      clr_f(); f[10] = 6; f[3] = 6; f[15] = 6;
      run_win(66, -1);
      chk("t4.idx", int'(widx[1]), 3);
      chk("t4.count", int'(cnt[1]), 3);

      // Quiet window, then spikes while idle.
      clr_f();
      run_win(66, -1);
      for (int t = 0; t < 8; t++) cyc(0, N'($urandom));
      chk("t5.count", int'(cnt[0]), 0);
      chk("t5.valid", int'(wval[0]), 0);

      // Mask scenario, then restart at cycle 20 of an inhibited window.
      clr_f(); f[1] = 5; f[13] = 7; f[4] = 9;
      run_win(12, -1);
`ifdef KWTA_MASK_OUT_EN
      chk("t6.mask", int'(msk[1]), 16'h2002);
`endif
      run_win(70, 20);

      // Restart on the exact last cycle of a window.
      clr_f(); f[7] = 2;
      run_win(70, 64);

      // Reset mid-window while inhibit is asserted.
      clr_f(); f[2] = 3;
      run_win(10, -1);
      @(negedge clk);
      gamma_start = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("t1.inhibit", int'(inh[0]), 0);
      chk("t1.count", int'(cnt[0]), 0);
      chk("t1.idx", int'(widx[0]), 0);
      chk("t1.valid", int'(wval[0]), 0);
      chk("t1.done", int'(dn[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, '1);

      // Randomized windows with occasional aborts and idle gaps.
      for (int w = 0; w < 30; w++) begin
         int nc, ab;
         clr_f();
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 2) == 0) f[i] = $urandom_range(1, 40);
         nc = $urandom_range(10, 72);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nc - 1) : -1;
         run_win(nc, ab);
         for (int t = $urandom_range(0, 3); t > 0; t--) cyc(0, N'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
